// File: rtl/alarm_scheduler.sv
// -----------------------------------------------------------------------------
// alarm_scheduler
//
// This block is the user-facing controller that sits beside the timekeeping
// counter. It has two jobs:
//   * It runs the mode state machine (RUN -> SET_H -> SET_M -> ALM_H -> ALM_M).
//     This lets the user edit the clock time and the alarm time. When the clock
//     time is committed, the block issues a one-cycle load strobe to the
//     timekeeper.
//   * It holds the alarm time and compares it with the live time. It also
//     sequences the ring / snooze / stop behaviour of the alarm.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset (overrides every other input)
//   tick          one-cycle pulse per second
//   hour/minute/second   live time from the timekeeper
//   btn_mode      pulse: advance mode (acts as stop while the alarm is active in RUN)
//   btn_inc       pulse: increment the field being edited
//   btn_snooze    pulse: snooze a ringing alarm
//   btn_stop      pulse: stop the alarm
//   alarm_en      level: alarm armed
//   set_time      one-cycle load strobe to the timekeeper
//   key_hour/key_minute  time value to load
//   mode          0 RUN, 1 SET_H, 2 SET_M, 3 ALM_H, 4 ALM_M
//   alarm_hour/alarm_minute  stored alarm time
//   ring          high while ringing
//   snoozing      high while snoozing
// -----------------------------------------------------------------------------
module alarm_scheduler #(
  parameter int         RING_SECS    = 60,
  parameter int         SNOOZE_SECS  = 300,
  parameter int         MAX_SNOOZE   = 3,
  parameter int         EDIT_TIMEOUT = 30,
  parameter logic [5:0] ALM_RST_H    = 6'd7,
  parameter logic [5:0] ALM_RST_M    = 6'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [5:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  input  logic       alarm_en,
  output logic       set_time,
  output logic [5:0] key_hour,
  output logic [5:0] key_minute,
  output logic [2:0] mode,
  output logic [5:0] alarm_hour,
  output logic [5:0] alarm_minute,
  output logic       ring,
  output logic       snoozing
);

  localparam int RING_W = $clog2(RING_SECS + 1);
  localparam int SNZ_W  = $clog2(SNOOZE_SECS + 1);
  localparam int NUM_W  = $clog2(MAX_SNOOZE + 1);
  localparam int IDLE_W = $clog2(EDIT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    SET_H = 3'd1,
    SET_M = 3'd2,
    ALM_H = 3'd3,
    ALM_M = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_RING   = 2'd1,
    A_SNOOZE = 2'd2
  } alarm_e;

  mode_e             mode_q, mode_d;
  alarm_e            astate_q, astate_d;
  logic              set_time_q, set_time_d;
  logic [5:0]        key_hour_q, key_hour_d;
  logic [5:0]        key_minute_q, key_minute_d;
  logic [5:0]        alarm_hour_q, alarm_hour_d;
  logic [5:0]        alarm_minute_q, alarm_minute_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic [NUM_W-1:0]  snz_num_q, snz_num_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  logic any_btn;
  logic alarm_active;
  logic mode_is_stop;
  logic stop_req;
  logic trigger;

  // Increment with wrap. Using >= also pulls an out-of-range value back to 0.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
    return (v >= max_v) ? 6'd0 : v + 6'd1;
  endfunction

  assign any_btn      = btn_mode | btn_inc | btn_snooze | btn_stop;
  assign alarm_active = (astate_q != A_IDLE);
  // While the alarm is active, the mode button in RUN is swallowed as a stop.
  // This keeps the user from wandering into an edit mode while the alarm is ringing.
  assign mode_is_stop = btn_mode && (mode_q == RUN) && alarm_active;
  assign stop_req     = btn_stop || mode_is_stop;
  assign trigger      = alarm_en && (mode_q == RUN) && tick &&
                        (hour == alarm_hour_q) && (minute == alarm_minute_q) &&
                        (second == 6'd0);

  always_comb begin
    mode_d         = mode_q;
    astate_d       = astate_q;
    set_time_d     = 1'b0;
    key_hour_d     = key_hour_q;
    key_minute_d   = key_minute_q;
    alarm_hour_d   = alarm_hour_q;
    alarm_minute_d = alarm_minute_q;
    ring_cnt_d     = ring_cnt_q;
    snz_cnt_d      = snz_cnt_q;
    snz_num_d      = snz_num_q;
    idle_cnt_d     = idle_cnt_q;

    // Inactivity counter. It saturates so that it can sit in RUN indefinitely.
    if (any_btn) begin
      idle_cnt_d = '0;
    end else if (tick && (idle_cnt_q != IDLE_W'(EDIT_TIMEOUT))) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end

    // Mode FSM. The mode button wins over increment in the same cycle.
    if (btn_mode && !mode_is_stop) begin
      unique case (mode_q)
        RUN: begin
          mode_d       = SET_H;
          key_hour_d   = hour;
          key_minute_d = minute;
        end
        SET_H: mode_d = SET_M;
        SET_M: begin
          mode_d     = ALM_H;
          set_time_d = 1'b1;
        end
        ALM_H:   mode_d = ALM_M;
        ALM_M:   mode_d = RUN;
        default: mode_d = RUN;
      endcase
    end else if (btn_inc) begin
      unique case (mode_q)
        SET_H:   key_hour_d     = wrap_inc(key_hour_q, 6'd23);
        SET_M:   key_minute_d   = wrap_inc(key_minute_q, 6'd59);
        ALM_H:   alarm_hour_d   = wrap_inc(alarm_hour_q, 6'd23);
        ALM_M:   alarm_minute_d = wrap_inc(alarm_minute_q, 6'd59);
        default: ;
      endcase
    end else if ((mode_q != RUN) && (idle_cnt_d == IDLE_W'(EDIT_TIMEOUT))) begin
      // An abandoned edit falls back to RUN without committing the time.
      mode_d = RUN;
    end

    // Alarm FSM
    unique case (astate_q)
      A_IDLE: begin
        if (trigger) begin
          astate_d   = A_RING;
          ring_cnt_d = RING_W'(RING_SECS);
          snz_num_d  = '0;
        end
      end
      A_RING: begin
        if (!alarm_en || stop_req) begin
          astate_d = A_IDLE;
        end else if (btn_snooze) begin
          if (snz_num_q < NUM_W'(MAX_SNOOZE)) begin
            astate_d  = A_SNOOZE;
            snz_cnt_d = SNZ_W'(SNOOZE_SECS);
            snz_num_d = snz_num_q + NUM_W'(1);
          end else begin
            // The snooze allowance is used up, so this press stops the alarm.
            astate_d = A_IDLE;
          end
        end else if (tick) begin
          if (ring_cnt_q <= RING_W'(1)) begin
            astate_d   = A_IDLE;
            ring_cnt_d = '0;
          end else begin
            ring_cnt_d = ring_cnt_q - RING_W'(1);
          end
        end
      end
      A_SNOOZE: begin
        if (!alarm_en || stop_req) begin
          astate_d = A_IDLE;
        end else if (tick) begin
          if (snz_cnt_q <= SNZ_W'(1)) begin
            astate_d   = A_RING;
            snz_cnt_d  = '0;
            ring_cnt_d = RING_W'(RING_SECS);
          end else begin
            snz_cnt_d = snz_cnt_q - SNZ_W'(1);
          end
        end
      end
      default: astate_d = A_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q         <= RUN;
      astate_q       <= A_IDLE;
      set_time_q     <= 1'b0;
      key_hour_q     <= 6'd0;
      key_minute_q   <= 6'd0;
      alarm_hour_q   <= ALM_RST_H;
      alarm_minute_q <= ALM_RST_M;
      ring_cnt_q     <= '0;
      snz_cnt_q      <= '0;
      snz_num_q      <= '0;
      idle_cnt_q     <= '0;
    end else begin
      mode_q         <= mode_d;
      astate_q       <= astate_d;
      set_time_q     <= set_time_d;
      key_hour_q     <= key_hour_d;
      key_minute_q   <= key_minute_d;
      alarm_hour_q   <= alarm_hour_d;
      alarm_minute_q <= alarm_minute_d;
      ring_cnt_q     <= ring_cnt_d;
      snz_cnt_q      <= snz_cnt_d;
      snz_num_q      <= snz_num_d;
      idle_cnt_q     <= idle_cnt_d;
    end
  end

  assign mode         = mode_q;
  assign set_time     = set_time_q;
  assign key_hour     = key_hour_q;
  assign key_minute   = key_minute_q;
  assign alarm_hour   = alarm_hour_q;
  assign alarm_minute = alarm_minute_q;
  assign ring         = (astate_q == A_RING);
  assign snoozing     = (astate_q == A_SNOOZE);

endmodule

// File: tb/tb_alarm_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alarm_scheduler
//
// This bench uses a scoreboard. Each stimulus cycle runs a behavioural model
// and pushes the expected outputs for the following clock edge. A separate
// monitor pops and compares those expectations after every edge. Directed
// scenarios add point checks against fixed values.
// -----------------------------------------------------------------------------
module tb_alarm_scheduler;
  localparam int RING = 60;
  localparam int SNZ  = 300;
  localparam int MAXS = 3;
  localparam int TO   = 30;

  logic       clk = 1'b0;
  logic       rst, tick, btn_mode, btn_inc, btn_snooze, btn_stop, alarm_en;
  logic [5:0] hour, minute, second;
  logic       set_time, ring, snoozing;
  logic [5:0] key_hour, key_minute, alarm_hour, alarm_minute;
  logic [2:0] mode;

  always #5 clk = ~clk;

  alarm_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick),
    .hour(hour), .minute(minute), .second(second),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_snooze(btn_snooze),
    .btn_stop(btn_stop), .alarm_en(alarm_en),
    .set_time(set_time), .key_hour(key_hour), .key_minute(key_minute),
    .mode(mode), .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
    .ring(ring), .snoozing(snoozing)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [29:0] exp_q[$];
  logic [29:0] mon_e, mon_a;

  // Reference model state. Times are plain integers, the mode is 0..4, and
  // the alarm is 0 idle / 1 ringing / 2 snoozing.
  int m_mode = 0, m_set = 0, m_kh = 0, m_km = 0, m_ah = 7, m_am = 0;
  int m_idle = 0, m_alarm = 0, m_ring_left = 0, m_snz_left = 0, m_snz_used = 0;

  task automatic model_step();
    bit any, mstop, stopreq, trig;
    int nidle;
    if (rst) begin
      m_mode = 0; m_set = 0; m_kh = 0; m_km = 0; m_ah = 7; m_am = 0;
      m_idle = 0; m_alarm = 0; m_ring_left = 0; m_snz_left = 0; m_snz_used = 0;
    end else begin
      any     = btn_mode | btn_inc | btn_snooze | btn_stop;
      mstop   = btn_mode && (m_mode == 0) && (m_alarm != 0);
      stopreq = btn_stop || mstop;
      trig    = alarm_en && (m_mode == 0) && tick && (int'(hour) == m_ah) &&
                (int'(minute) == m_am) && (second == 6'd0);
      case (m_alarm)
        0: if (trig) begin m_alarm = 1; m_ring_left = RING; m_snz_used = 0; end
        1: begin
          if (!alarm_en || stopreq) m_alarm = 0;
          else if (btn_snooze) begin
            if (m_snz_used < MAXS) begin
              m_alarm = 2; m_snz_left = SNZ; m_snz_used++;
            end else m_alarm = 0;
          end else if (tick) begin
            m_ring_left--;
            if (m_ring_left == 0) m_alarm = 0;
          end
        end
        default: begin
          if (!alarm_en || stopreq) m_alarm = 0;
          else if (tick) begin
            m_snz_left--;
            if (m_snz_left == 0) begin m_alarm = 1; m_ring_left = RING; end
          end
        end
      endcase
      m_set = 0;
      nidle = any ? 0 : m_idle + (tick ? 1 : 0);
      if (btn_mode && !mstop) begin
        if (m_mode == 0) begin m_kh = int'(hour); m_km = int'(minute); end
        if (m_mode == 2) m_set = 1;
        m_mode = (m_mode + 1) % 5;
      end else if (btn_inc) begin
        case (m_mode)
          1: m_kh = (m_kh + 1) % 24;
          2: m_km = (m_km + 1) % 60;
          3: m_ah = (m_ah + 1) % 24;
          4: m_am = (m_am + 1) % 60;
          default: ;
        endcase
      end else if ((m_mode != 0) && (nidle >= TO)) begin
        m_mode = 0;
      end
      m_idle = nidle;
    end
  endtask

  function automatic logic [29:0] model_out();
    return {3'(m_mode), 1'(m_set), 6'(m_kh), 6'(m_km), 6'(m_ah), 6'(m_am),
            (m_alarm == 1), (m_alarm == 2)};
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One clock cycle of stimulus. It is called at a negedge and returns at the next negedge.
  task automatic cyc(input bit bm, input bit bi, input bit bs, input bit bt, input bit tk);
    btn_mode = bm; btn_inc = bi; btn_snooze = bs; btn_stop = bt; tick = tk;
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compares every registered output set against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {mode, set_time, key_hour, key_minute, alarm_hour, alarm_minute, ring, snoozing};
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL outputs t=%0t: got mode=%0d st=%0d kh=%0d km=%0d ah=%0d am=%0d ring=%0d snz=%0d, expected mode=%0d st=%0d kh=%0d km=%0d ah=%0d am=%0d ring=%0d snz=%0d",
                 $time, mon_a[29:27], mon_a[26], mon_a[25:20], mon_a[19:14], mon_a[13:8], mon_a[7:2], mon_a[1], mon_a[0],
                 mon_e[29:27], mon_e[26], mon_e[25:20], mon_e[19:14], mon_e[13:8], mon_e[7:2], mon_e[1], mon_e[0]);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic fire_alarm();
    second = 6'd0;
    cyc(0, 0, 0, 0, 1);
    second = 6'd1;
  endtask

  initial begin
    rst = 1'b1; tick = 0; btn_mode = 0; btn_inc = 0; btn_snooze = 0; btn_stop = 0;
    alarm_en = 0; hour = 0; minute = 0; second = 0;
    @(negedge clk);

    // Reset state
    hour = 6'd10; minute = 6'd20; second = 6'd5;
    do_reset();
    chk("rst_mode", mode, 0);
    chk("rst_alarm_hour", alarm_hour, 7);
    chk("rst_alarm_minute", alarm_minute, 0);
    chk("rst_ring", ring, 0);
    $display("scenario reset: mode=%0d alarm=%0d:%0d", mode, alarm_hour, alarm_minute);

    // Edit sequence
    cyc(1, 0, 0, 0, 0);
    chk("edit_enter_mode", mode, 1);
    chk("edit_capture_hour", key_hour, 10);
    repeat (3) cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (41) cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("edit_set_time", set_time, 1);
    chk("edit_key_hour", key_hour, 13);
    chk("edit_key_minute", key_minute, 1);
    chk("edit_mode_alm_h", mode, 3);
    cyc(0, 0, 0, 0, 0);
    chk("edit_set_time_drop", set_time, 0);
    $display("scenario edit: key=%0d:%0d mode=%0d", key_hour, key_minute, mode);

    // Alarm set with wrap
    repeat (16) cyc(0, 1, 0, 0, 0);
    chk("alm_hour_23", alarm_hour, 23);
    cyc(0, 1, 0, 0, 0);
    chk("alm_hour_wrap", alarm_hour, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (59) cyc(0, 1, 0, 0, 0);
    chk("alm_min_59", alarm_minute, 59);
    cyc(0, 1, 0, 0, 0);
    chk("alm_min_wrap", alarm_minute, 0);
    cyc(1, 0, 0, 0, 0);
    chk("alm_back_run", mode, 0);
    $display("scenario alarm_set: alarm=%0d:%0d mode=%0d", alarm_hour, alarm_minute, mode);

    // Trigger and auto-stop
    do_reset();
    alarm_en = 1; hour = 6'd7; minute = 6'd0;
    fire_alarm();
    chk("trig_ring", ring, 1);
    repeat (59) cyc(0, 0, 0, 0, 1);
    chk("trig_ring_59", ring, 1);
    cyc(0, 0, 0, 0, 1);
    chk("trig_autostop", ring, 0);
    $display("scenario trigger: ring=%0d", ring);

    // Snooze three times, then the fourth press acts as stop
    fire_alarm();
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 0, 0);
      chk("snz_snoozing", snoozing, 1);
      chk("snz_ring_off", ring, 0);
      repeat (299) cyc(0, 0, 0, 0, 1);
      chk("snz_still", snoozing, 1);
      cyc(0, 0, 0, 0, 1);
      chk("snz_rering", ring, 1);
    end
    cyc(0, 0, 1, 0, 0);
    chk("snz4_ring", ring, 0);
    chk("snz4_snoozing", snoozing, 0);
    $display("scenario snooze: ring=%0d snoozing=%0d", ring, snoozing);

    // Edit timeout; the alarm must not fire outside RUN
    do_reset();
    cyc(1, 0, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 0);
    repeat (29) cyc(0, 0, 0, 0, 1);
    chk("to_not_yet", mode, 1);
    cyc(0, 0, 0, 0, 1);
    chk("to_run", mode, 0);
    cyc(1, 0, 0, 0, 0);
    fire_alarm();
    chk("to_no_ring_edit", ring, 0);
    $display("scenario timeout: mode=%0d ring=%0d", mode, ring);

    // Simultaneous events
    cyc(1, 1, 0, 0, 0);
    chk("sim_mode_wins", mode, 2);
    chk("sim_key_hour", key_hour, 7);
    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("sim_run", mode, 0);
    fire_alarm();
    chk("sim_ring", ring, 1);
    cyc(0, 0, 1, 1, 0);
    chk("sim_stop_wins_ring", ring, 0);
    chk("sim_stop_wins_snz", snoozing, 0);
    fire_alarm();
    cyc(1, 0, 0, 0, 0);
    chk("mode_as_stop_ring", ring, 0);
    chk("mode_as_stop_mode", mode, 0);
    fire_alarm();
    alarm_en = 0;
    cyc(0, 0, 0, 0, 0);
    chk("disarm_ring", ring, 0);
    alarm_en = 1;
    fire_alarm();
    cyc(0, 0, 1, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 1);
    rst = 1'b0;
    chk("rst_mid_snz", snoozing, 0);
    chk("rst_mid_ring_ah", alarm_hour, 7);
    repeat (2) cyc(1, 0, 0, 0, 0);
    rst = 1'b1;
    cyc(1, 0, 0, 0, 0);
    rst = 1'b0;
    chk("rst_mid_edit_st", set_time, 0);
    chk("rst_mid_edit_mode", mode, 0);
    $display("scenario simultaneous: mode=%0d ring=%0d", mode, ring);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst      = ($urandom_range(0, 599) == 0);
      alarm_en = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 3) == 0) begin
        hour = 6'(m_ah); minute = 6'(m_am);
      end else begin
        hour = 6'($urandom_range(0, 23)); minute = 6'($urandom_range(0, 59));
      end
      second = 6'($urandom_range(0, 2));
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 1) == 0);
    end
    $display("scenario random: 4000 cycles");

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
